// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per enabled clock with frame_start/frame_done markers.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               frame_done_q, frame_done_d;
  logic               last_bit;
  logic               transfer;

  // The last bit being consumed frees the shifter on the same edge, which is
  // what lets a waiting word follow with no idle gap.
  assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT) && ser_en;
  assign load_ready = rst && ((state_q == IDLE) || last_bit);
  assign transfer   = load_valid && load_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = last_bit;

    if (transfer) begin
      state_d   = SHIFT;
      shift_d   = load_data;
      bit_cnt_d = '0;
    end else if ((state_q == SHIFT) && ser_en) begin
      if (last_bit) begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
      end else begin
        if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], 1'b0};
        else           shift_d = {1'b0, shift_q[WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (!rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ser_valid   = (state_q == SHIFT);
  assign ser_out     = ser_valid && shift_q[MSB_FIRST ? WIDTH-1 : 0];
  assign frame_start = ser_valid && (bit_cnt_q == '0);
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a bit-queue model of the frame in flight.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, load_valid, ser_en;
  logic [W-1:0] load_data;

  logic m_ready, m_out, m_valid, m_start, m_done;
  logic l_ready, l_out, l_valid, l_start, l_done;

  int checks = 0;
  int errors = 0;

  bit q_m[$];
  bit q_l[$];
  bit exp_done = 1'b0;

  logic [W-1:0] seq_m, seq_l;
  int valid_cnt, done_cnt;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(m_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(m_out), .ser_valid(m_valid),
    .frame_start(m_start), .frame_done(m_done)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(l_ready),
    .load_data(load_data), .ser_en(ser_en), .ser_out(l_out), .ser_valid(l_valid),
    .frame_start(l_start), .frame_done(l_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic clear_obs();
    seq_m = '0;
    seq_l = '0;
    valid_cnt = 0;
    done_cnt = 0;
  endtask

  // One clock: apply inputs, compare outputs with the model, advance the model.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] d, input logic en);
    logic exp_ready;
    rst = r; load_valid = lv; load_data = d; ser_en = en;
    #1;
    exp_ready = r && (q_m.size() == 0 || (q_m.size() == 1 && en));
    check("load_ready_m", 32'(m_ready), 32'(exp_ready));
    check("load_ready_l", 32'(l_ready), 32'(exp_ready));
    check("ser_valid_m", 32'(m_valid), 32'(q_m.size() != 0));
    check("ser_valid_l", 32'(l_valid), 32'(q_l.size() != 0));
    check("ser_out_m", 32'(m_out), 32'((q_m.size() != 0) ? q_m[0] : 1'b0));
    check("ser_out_l", 32'(l_out), 32'((q_l.size() != 0) ? q_l[0] : 1'b0));
    check("frame_start_m", 32'(m_start), 32'(q_m.size() == W));
    check("frame_start_l", 32'(l_start), 32'(q_l.size() == W));
    check("frame_done_m", 32'(m_done), 32'(exp_done));
    check("frame_done_l", 32'(l_done), 32'(exp_done));

    if (m_valid === 1'b1) begin
      seq_m = {seq_m[W-2:0], m_out};
      seq_l = {seq_l[W-2:0], l_out};
      valid_cnt++;
    end
    if (m_done === 1'b1) done_cnt++;

    exp_done = r && (q_m.size() == 1) && en;
    if (en && q_m.size() != 0) begin
      void'(q_m.pop_front());
      void'(q_l.pop_front());
    end
    if (lv && exp_ready) begin
      for (int i = 0; i < W; i++) begin
        q_m.push_back(d[W-1-i]);
        q_l.push_back(d[i]);
      end
    end
    if (!r) begin
      q_m.delete();
      q_l.delete();
      exp_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [W-1:0] w);
    clear_obs();
    cycle(1'b1, 1'b1, w, 1'b1);
    for (int i = 0; i < W + 2; i++) cycle(1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_data = '0; ser_en = 1'b0;
    @(posedge clk);
    #1;

    // Reset held with a valid word offered: nothing accepted.
    clear_obs();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hFF, 1'b1);
    check("rst_no_frame", 32'(valid_cnt), 32'd0);

    // Single frame, MSB first and LSB first in parallel.
    run_frame(8'hA5);
    check("a5_seq_m", 32'(seq_m), 32'h0A5);
    check("a5_seq_l", 32'(seq_l), 32'(rev(8'hA5)));
    check("a5_valid_cnt", 32'(valid_cnt), 32'd8);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);

    // Back-to-back frames: second word held valid until accepted on the last bit.
    clear_obs();
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < W; i++) cycle(1'b1, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < W + 2; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("b2b_valid_cnt", 32'(valid_cnt), 32'd16);
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);
    check("b2b_seq_m", 32'(seq_m), 32'h03C);

    // Stall for three cycles at bit_cnt 3.
    clear_obs();
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("stall_valid_cnt", 32'(valid_cnt), 32'd11);
    check("stall_done_cnt", 32'(done_cnt), 32'd1);

    // Reset mid-frame at bit_cnt 4, then a fresh frame.
    clear_obs();
    cycle(1'b1, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b1);
    check("abort_done_cnt", 32'(done_cnt), 32'd0);
    run_frame(8'h81);
    check("post_abort_seq_m", 32'(seq_m), 32'h081);
    check("post_abort_done", 32'(done_cnt), 32'd1);

    // Bit order at the word boundaries.
    run_frame(8'h01);
    check("lsb_01_seq_l", 32'(seq_l), 32'h080);
    check("msb_01_seq_m", 32'(seq_m), 32'h001);
    run_frame(8'h80);
    check("lsb_80_seq_l", 32'(seq_l), 32'h001);

    // Random traffic with stalls and occasional reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
            W'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < W + 4; i++) cycle(1'b1, 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
